cam_capture_ctrl: RTL and testbench
===================================

// Module: cam_capture_ctrl
// PURPOSE
//  Sequences capture of DVP camera frames (vsync/href/8-bit data) on the cam_pclk domain.
//  Software arms N frames; the block aligns to vsync, counts lines and bytes, and packs bytes into 32-bit words.
//  Words go out on a valid/ready stream toward the frame-buffer DMA. Size and overflow faults are flagged sticky.
// PARAMETERS
//  W_BYTES  12  width of cfg_width_bytes and the byte counter
//  W_LINES  11  width of cfg_height and the line counter
// PORTS
//  cam_pclk         in   1        sole clock; all logic on posedge
//  cam_rst          in   1        synchronous reset, active-high
//  cfg_start        in   1        1-cycle pulse: arm capture (ignored while busy)
//  cfg_stop         in   1        1-cycle pulse: finish current frame, then idle
//  cfg_frames       in   8        frames to capture; 0 = continuous
//  cfg_width_bytes  in   W_BYTES  bytes per line (2*pixels)
//  cfg_height       in   W_LINES  lines per frame
//  cam_vsync        in   1        frame sync, high = blanking/start
//  cam_href         in   1        line valid
//  cam_data         in   8        pixel byte
//  out_data         out  32       packed word; first byte in [7:0]
//  out_valid        out  1        word valid
//  out_ready        in   1        sink accepts word
//  out_sof          out  1        qualifies out_data: first word of frame
//  out_eof          out  1        qualifies out_data: last word of frame
//  busy             out  1        state != IDLE
//  frame_done       out  1        1-cycle pulse per complete frame
//  frame_cnt        out  8        complete frames since cfg_start (wraps at 255)
//  err_overflow     out  1        sticky: word dropped, sink not ready
//  err_size         out  1        sticky: line length or frame height mismatch
//  err_clear        in   1        clears both sticky errors
// BEHAVIOUR
//  Reset: every output is 0. State is IDLE. Counters and the packer are cleared.
//  Inputs: vsync/href/data are registered once (1 cycle). Edges are detected on the registered copies.
//  FSM:
//   IDLE     : start & !stop -> WAIT_VS. Loads frames_left = cfg_frames and clears frame_cnt. Start & stop together: stay IDLE.
//   WAIT_VS  : vsync rise -> IN_VS. stop -> IDLE immediately.
//   IN_VS    : vsync fall -> FRAME. Clears line_cnt. Arms sof.
//   FRAME    : each registered href-high cycle pushes one byte into the packer.
//    - href fall: if byte_cnt != cfg_width_bytes, set err_size. Flush any partial word, zero-padded in the upper bytes. line_cnt++.
//    - line_cnt reaches cfg_height: tag last word eof, pulse frame_done, increment frame_cnt.
//      Then go to IDLE if stop is pending or frames_left hits 1 (nonzero mode). Otherwise go to WAIT_VS.
//    - vsync rise before height is reached: set err_size, drop the partial word, no frame_done, go to IN_VS (new frame).
//  cfg_stop in FRAME latches stop_pending. The frame completes normally, then the block returns to IDLE.
//  href outside FRAME is ignored. The byte counter saturates at all-ones.
//  Packer: 4th byte -> word valid on out_data the following cycle (2 cycles after the byte on the pins).
//  sof is set on the first word of a frame. eof is set on the word that ends the last line, including a flushed partial word.
//  Output register, single entry: holds while out_valid & !out_ready.
//   A new word completing while it is held is dropped and err_overflow is set.
//   Flags on the held word are kept unchanged.
//  err_clear together with a new error event: the error wins and the flag stays set.
//  Mid-frame reset: outputs clear in the same cycle; no eof is emitted.
// STRUCTURE
//  cam_pkg: cam_state_e {IDLE, WAIT_VS, IN_VS, FRAME}, default W_BYTES/W_LINES, and the word type.
//  Sub-module cam_byte_packer: byte shift, index counter, flush/zero-pad, word_valid/sof/eof tags.
// TESTING
//  1 Arm frames=1, width=200, height=70, 100x70 emulator, ready=1.
//    -> 3500 words; sof on word 0, eof on word 3499, one frame_done, frame_cnt=1, busy falls, no errors.
//  2 First byte sequence 0xEE,0xDD,0xBB,0x77 -> out_data=0x77BBDDEE.
//  3 width=198 with emulator lines of 200 bytes -> err_size set after line 0. err_clear -> 0.
//  4 out_ready held 0 for 8 cycles mid-line -> first word held stable, err_overflow=1, later words resume.
//  5 frames=0 streaming, stop pulse mid-frame 2 -> frame 2 completes with eof. frame_cnt=3 counts frames 0, 1, 2. IDLE afterward.
//  6 vsync forced high after line 40 -> err_size, no frame_done. Next frame captured fully with sof.
//    cam_rst mid-line -> all outputs 0 next cycle.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and defaults for the DVP camera capture controller.
//   cam_state_e : capture sequencer states
//   cam_word_t  : packed 32-bit output word, first byte in [7:0]
package cam_pkg;

  localparam int unsigned CAM_W_BYTES = 12;
  localparam int unsigned CAM_W_LINES = 11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    IN_VS,
    FRAME
  } cam_state_e;

  typedef logic [31:0] cam_word_t;

endpackage

// File: rtl/cam_byte_packer.sv
// Packs a byte stream into 32-bit words, first byte in the low lane.
//   i_clk/i_rst   : clock, synchronous active-high reset
//   i_clear       : discard any partial word
//   i_push/i_byte : one byte per asserted cycle
//   i_flush       : emit a partial word zero-padded in the upper bytes
//   i_eof         : tag the word emitted this cycle as end of frame
//   i_arm_sof     : tag the next emitted word as start of frame
//   o_word_valid  : a word completes this cycle (combinational)
//   o_word/o_sof/o_eof : word and its tags, valid with o_word_valid
module cam_byte_packer
  import cam_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_push,
  input  logic [7:0] i_byte,
  input  logic       i_flush,
  input  logic       i_eof,
  input  logic       i_arm_sof,
  output logic       o_word_valid,
  output cam_word_t  o_word,
  output logic       o_sof,
  output logic       o_eof
);

  logic [1:0]  r_idx;
  logic [23:0] r_buf;
  logic        r_sof_pend;
  logic        w_full;
  logic        w_part;

  // The 4th byte bypasses the buffer so the word is registered downstream
  // in the same cycle it completes.
  assign w_full       = i_push & (r_idx == 2'd3);
  assign w_part       = i_flush & ~i_push & (r_idx != 2'd0);
  assign o_word_valid = w_full | w_part;
  assign o_sof        = o_word_valid & r_sof_pend;
  assign o_eof        = o_word_valid & i_eof;

  always_comb begin
    o_word = '0;
    if (w_full) begin
      o_word = {i_byte, r_buf};
    end else begin
      case (r_idx)
        2'd1:    o_word = {24'd0, r_buf[7:0]};
        2'd2:    o_word = {16'd0, r_buf[15:0]};
        2'd3:    o_word = {8'd0, r_buf[23:0]};
        default: o_word = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_idx <= '0;
      r_buf <= '0;
    end else if (i_push) begin
      case (r_idx)
        2'd0:    r_buf[7:0]   <= i_byte;
        2'd1:    r_buf[15:8]  <= i_byte;
        2'd2:    r_buf[23:16] <= i_byte;
        default: ;
      endcase
      r_idx <= r_idx + 2'd1;
    end else if (i_flush) begin
      r_idx <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sof_pend <= 1'b0;
    end else if (i_arm_sof) begin
      r_sof_pend <= 1'b1;
    end else if (o_word_valid) begin
      r_sof_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/cam_capture_ctrl.sv
// DVP camera frame capture sequencer on the cam_pclk domain.
// Arms N frames (0 = continuous), aligns to vsync, counts lines/bytes,
// packs bytes into 32-bit words and streams them out on valid/ready.
//   cfg_*              : start/stop pulses, frame count, line width, height
//   cam_vsync/href/data: camera pins, registered once on entry
//   out_*              : single-entry word register with sof/eof tags
//   busy/frame_done/frame_cnt : status
//   err_overflow/err_size     : sticky faults, cleared by err_clear
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned W_BYTES = CAM_W_BYTES,
  parameter int unsigned W_LINES = CAM_W_LINES
) (
  input  logic               cam_pclk,
  input  logic               cam_rst,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic [7:0]         cfg_frames,
  input  logic [W_BYTES-1:0] cfg_width_bytes,
  input  logic [W_LINES-1:0] cfg_height,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic [7:0]         cam_data,
  output logic [31:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic               out_eof,
  output logic               busy,
  output logic               frame_done,
  output logic [7:0]         frame_cnt,
  output logic               err_overflow,
  output logic               err_size,
  input  logic               err_clear
);

  cam_state_e         r_state, w_state_nx;
  logic               r_vs, r_vs_d, r_hr, r_hr_d;
  logic [7:0]         r_d;
  logic               r_stop_pend;
  logic [7:0]         r_frames_left;
  logic [7:0]         r_frame_cnt;
  logic               r_frame_done;
  logic [W_LINES-1:0] r_line_cnt;
  logic [W_BYTES-1:0] r_byte_cnt, w_bcnt_nx;
  cam_word_t          r_out_data;
  logic               r_out_valid, r_out_sof, r_out_eof;
  logic               r_err_ovf, r_err_size;

  logic      w_vs_rise, w_vs_fall, w_hr_fall, w_last_line, w_eof_tag;
  logic      w_start, w_arm, w_push, w_flush, w_line_end, w_done, w_abort, w_size_bad;
  logic      w_pk_valid, w_pk_sof, w_pk_eof, w_drop;
  cam_word_t w_pk_word;

  assign w_vs_rise   = r_vs & ~r_vs_d;
  assign w_vs_fall   = ~r_vs & r_vs_d;
  assign w_hr_fall   = ~r_hr & r_hr_d;
  assign w_last_line = (r_line_cnt == (cfg_height - W_LINES'(1)));
  assign w_bcnt_nx   = (r_byte_cnt == '1) ? r_byte_cnt : r_byte_cnt + W_BYTES'(1);
  // A full word is emitted before the href fall is visible, so eof on a
  // word-aligned last line is predicted from the byte count; a flushed
  // partial word on the last line is tagged directly.
  assign w_eof_tag   = w_last_line & (w_push ? (w_bcnt_nx == cfg_width_bytes) : 1'b1);
  assign w_drop      = w_pk_valid & r_out_valid & ~out_ready;

  always_ff @(posedge cam_pclk) begin
    if (cam_rst) begin
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
      r_hr   <= 1'b0;
      r_hr_d <= 1'b0;
      r_d    <= '0;
    end else begin
      r_vs   <= cam_vsync;
      r_vs_d <= r_vs;
      r_hr   <= cam_href;
      r_hr_d <= r_hr;
      r_d    <= cam_data;
    end
  end

  always_ff @(posedge cam_pclk) begin
    if (cam_rst) r_state <= IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_arm      = 1'b0;
    w_push     = 1'b0;
    w_flush    = 1'b0;
    w_line_end = 1'b0;
    w_done     = 1'b0;
    w_abort    = 1'b0;
    w_size_bad = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_start && !cfg_stop) begin
          w_start    = 1'b1;
          w_state_nx = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (cfg_stop)       w_state_nx = IDLE;
        else if (w_vs_rise) w_state_nx = IN_VS;
      end
      IN_VS: begin
        if (w_vs_fall) begin
          w_arm      = 1'b1;
          w_state_nx = FRAME;
        end
      end
      FRAME: begin
        w_push = r_hr;
        if (w_hr_fall) begin
          w_flush    = 1'b1;
          w_line_end = 1'b1;
          w_size_bad = (r_byte_cnt != cfg_width_bytes);
          if (w_last_line) begin
            w_done     = 1'b1;
            w_state_nx = (r_stop_pend || cfg_stop || r_frames_left == 8'd1) ? IDLE : WAIT_VS;
          end
        end
        if (w_vs_rise && !w_done) begin
          w_abort    = 1'b1;
          w_size_bad = 1'b1;
          w_push     = 1'b0;
          w_flush    = 1'b0;
          w_state_nx = IN_VS;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge cam_pclk) begin
    if (cam_rst) begin
      r_stop_pend   <= 1'b0;
      r_frames_left <= '0;
      r_frame_cnt   <= '0;
      r_frame_done  <= 1'b0;
      r_line_cnt    <= '0;
      r_byte_cnt    <= '0;
    end else begin
      r_frame_done <= w_done;
      if (w_start) begin
        r_frames_left <= cfg_frames;
        r_frame_cnt   <= '0;
      end else if (w_done) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        if (r_frames_left != 8'd0) r_frames_left <= r_frames_left - 8'd1;
      end
      if (w_arm || w_line_end) r_byte_cnt <= '0;
      else if (w_push)         r_byte_cnt <= w_bcnt_nx;
      if (w_arm)               r_line_cnt <= '0;
      else if (w_line_end)     r_line_cnt <= r_line_cnt + W_LINES'(1);
      if (w_state_nx == IDLE) r_stop_pend <= 1'b0;
      else if (cfg_stop && (r_state == IN_VS || r_state == FRAME)) r_stop_pend <= 1'b1;
    end
  end

  cam_byte_packer u_packer (
    .i_clk        (cam_pclk),
    .i_rst        (cam_rst),
    .i_clear      (w_arm | w_abort),
    .i_push       (w_push),
    .i_byte       (r_d),
    .i_flush      (w_flush),
    .i_eof        (w_eof_tag),
    .i_arm_sof    (w_arm),
    .o_word_valid (w_pk_valid),
    .o_word       (w_pk_word),
    .o_sof        (w_pk_sof),
    .o_eof        (w_pk_eof)
  );

  // A held word keeps its data and tags; a word completing behind it is lost.
  always_ff @(posedge cam_pclk) begin
    if (cam_rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else if (w_pk_valid && !w_drop) begin
      r_out_data  <= w_pk_word;
      r_out_valid <= 1'b1;
      r_out_sof   <= w_pk_sof;
      r_out_eof   <= w_pk_eof;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge cam_pclk) begin
    if (cam_rst) begin
      r_err_ovf  <= 1'b0;
      r_err_size <= 1'b0;
    end else begin
      if (w_drop)          r_err_ovf <= 1'b1;
      else if (err_clear)  r_err_ovf <= 1'b0;
      if (w_size_bad)      r_err_size <= 1'b1;
      else if (err_clear)  r_err_size <= 1'b0;
    end
  end

  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_sof      = r_out_sof;
  assign out_eof      = r_out_eof;
  assign busy         = (r_state != IDLE);
  assign frame_done   = r_frame_done;
  assign frame_cnt    = r_frame_cnt;
  assign err_overflow = r_err_ovf;
  assign err_size     = r_err_size;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
module tb_cam_capture_ctrl;

  typedef struct packed {
    logic        sof;
    logic        eof;
    logic [31:0] data;
  } rec_t;

  logic        cam_pclk = 1'b0;
  logic        cam_rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [7:0]  cfg_frames = 8'd0;
  logic [11:0] cfg_width_bytes = 12'd0;
  logic [10:0] cfg_height = 11'd0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sof;
  logic        out_eof;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        err_overflow;
  logic        err_size;
  logic        err_clear = 1'b0;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  logic g_fixed = 1'b0;
  logic [7:0] fixed4 [4] = '{8'hEE, 8'hDD, 8'hBB, 8'h77};

  cam_capture_ctrl #(.W_BYTES(12), .W_LINES(11)) dut (
    .cam_pclk(cam_pclk), .cam_rst(cam_rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_frames(cfg_frames), .cfg_width_bytes(cfg_width_bytes), .cfg_height(cfg_height),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .err_overflow(err_overflow), .err_size(err_size),
    .err_clear(err_clear)
  );

  always #5 cam_pclk = ~cam_pclk;

  always @(negedge cam_pclk) begin
    if (!cam_rst && out_valid && out_ready) got_q.push_back(rec_t'({out_sof, out_eof, out_data}));
    if (frame_done) n_done++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge cam_pclk);
    #1;
  endtask

  function automatic logic [7:0] gen(input int seed, input int l, input int i);
    if (g_fixed && l == 0 && i < 4) return fixed4[i];
    return 8'((seed * 29) + (l * 7) + (i * 3) + (i >> 2) + 1);
  endfunction

  // Camera emulator: vsync pulse, then nl lines of wb bytes; stops before
  // line abort_at. Records the words the sink should see for each full line.
  task automatic cam_frame(input int wb, input int nl, input int abort_at, input int seed);
    cam_vsync = 1'b1;
    repeat (4) tick();
    cam_vsync = 1'b0;
    repeat (4) tick();
    for (int l = 0; l < nl; l++) begin
      if (l == abort_at) break;
      for (int i = 0; i < wb; i++) begin
        cam_href = 1'b1;
        cam_data = gen(seed, l, i);
        tick();
      end
      cam_href = 1'b0;
      cam_data = 8'h00;
      repeat (6) tick();
      for (int w = 0; w < (wb + 3) / 4; w++) begin
        rec_t r;
        r.data = '0;
        for (int k = 0; k < 4; k++)
          if (w * 4 + k < wb) r.data[8*k +: 8] = gen(seed, l, w * 4 + k);
        r.sof = (l == 0 && w == 0);
        r.eof = (l == nl - 1 && w == (wb + 3) / 4 - 1);
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic setup(input logic [7:0] fr, input int wb, input int h);
    got_q.delete();
    exp_q.delete();
    n_done = 0;
    cfg_frames = fr;
    cfg_width_bytes = 12'(wb);
    cfg_height = 11'(h);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    cam_rst = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, out_sof, out_eof, busy, frame_done, err_overflow, err_size} !== 7'd0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {out_valid, out_sof, out_eof, busy, frame_done, err_overflow, err_size});
    end
    n_checks++;
    if ({out_data, frame_cnt} !== 40'd0) begin
      n_errors++;
      $display("FAIL reset_data: got data %h cnt %0d expected 0", out_data, frame_cnt);
    end
  endtask

  task automatic test_start_stop();
    cfg_start = 1'b1; cfg_stop = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL start_with_stop: busy %b expected 0", busy); end
    setup(8'd1, 8, 1);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL armed_busy: busy %b expected 1", busy); end
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL stop_in_wait_vs: busy %b expected 0", busy); end
  endtask

  task automatic test_single_frame();
    int nbad = 0;
    setup(8'd1, 200, 70);
    cam_frame(200, 70, -1, 1);
    repeat (4) tick();
    n_checks++;
    if (got_q.size() != 3500) begin
      n_errors++; $display("FAIL word_count: got %0d expected 3500", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    n_checks++;
    if (nbad != 0) begin n_errors++; $display("FAIL frame_words: %0d bad words expected 0", nbad); end
    n_checks++;
    if ((got_q.size() > 0 ? got_q[0].sof : 1'b0) !== 1'b1) begin
      n_errors++; $display("FAIL sof_word0: got 0 expected 1");
    end
    n_checks++;
    if ((got_q.size() > 3499 ? got_q[3499].eof : 1'b0) !== 1'b1) begin
      n_errors++; $display("FAIL eof_word3499: got 0 expected 1");
    end
    n_checks++;
    if (n_done != 1 || frame_cnt !== 8'd1) begin
      n_errors++; $display("FAIL frame_done: got %0d pulses cnt %0d expected 1 and 1", n_done, frame_cnt);
    end
    n_checks++;
    if ({busy, err_overflow, err_size} !== 3'b000) begin
      n_errors++; $display("FAIL end_state: busy/ovf/size %b expected 000", {busy, err_overflow, err_size});
    end
  endtask

  task automatic test_byte_order();
    int nbad = 0;
    g_fixed = 1'b1;
    setup(8'd1, 6, 1);
    cam_frame(6, 1, -1, 2);
    repeat (4) tick();
    g_fixed = 1'b0;
    n_checks++;
    if ((got_q.size() > 0 ? got_q[0].data : 32'd0) !== 32'h77BBDDEE) begin
      n_errors++;
      $display("FAIL byte_order: got %h expected 77bbddee", got_q.size() > 0 ? got_q[0].data : 32'd0);
    end
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    n_checks++;
    if (nbad != 0 || got_q.size() != 2) begin
      n_errors++; $display("FAIL partial_pad_eof: %0d bad of %0d words expected 0 of 2", nbad, got_q.size());
    end
  endtask

  task automatic test_size_error();
    setup(8'd1, 198, 1);
    cam_frame(200, 1, -1, 3);
    repeat (4) tick();
    n_checks++;
    if (err_size !== 1'b1) begin n_errors++; $display("FAIL err_size_set: got %b expected 1", err_size); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_checks++;
    if (err_size !== 1'b0) begin n_errors++; $display("FAIL err_size_clear: got %b expected 0", err_size); end
  endtask

  task automatic test_overflow();
    setup(8'd1, 32, 2);
    fork
      cam_frame(32, 2, -1, 4);
      begin
        logic [31:0] held;
        int n = 0;
        int bad = 0;
        repeat (20) tick();
        out_ready = 1'b0;
        while (!out_valid && n < 6) begin tick(); n++; end
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL hold_valid: got %b expected 1", out_valid); end
        held = out_data;
        repeat (8) begin
          tick();
          if (out_valid !== 1'b1 || out_data !== held) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL hold_stable: %0d changed cycles expected 0", bad); end
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();
    n_checks++;
    if (err_overflow !== 1'b1) begin n_errors++; $display("FAIL err_overflow: got %b expected 1", err_overflow); end
    n_checks++;
    if (got_q.size() < 10 || got_q.size() > 15) begin
      n_errors++; $display("FAIL resume_count: got %0d words expected 10..15", got_q.size());
    end
    n_checks++;
    if ((got_q.size() > 0 ? got_q[got_q.size()-1].eof : 1'b0) !== 1'b1) begin
      n_errors++; $display("FAIL resume_eof: got 0 expected 1");
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_checks++;
    if (err_overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b expected 0", err_overflow); end
  endtask

  task automatic test_continuous_stop();
    int nbad = 0;
    setup(8'd0, 8, 3);
    cam_frame(8, 3, -1, 5);
    cam_frame(8, 3, -1, 6);
    fork
      cam_frame(8, 3, -1, 7);
      begin
        repeat (15) tick();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
      end
    join
    repeat (4) tick();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    n_checks++;
    if (nbad != 0 || got_q.size() != 18) begin
      n_errors++; $display("FAIL stream_words: %0d bad of %0d words expected 0 of 18", nbad, got_q.size());
    end
    n_checks++;
    if (frame_cnt !== 8'd3 || n_done != 3) begin
      n_errors++; $display("FAIL stream_frames: cnt %0d pulses %0d expected 3 and 3", frame_cnt, n_done);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL stream_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_vsync_abort();
    int nbad = 0;
    setup(8'd1, 16, 50);
    cam_frame(16, 50, 40, 8);
    cam_frame(16, 50, -1, 9);
    repeat (4) tick();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    n_checks++;
    if (nbad != 0 || got_q.size() != 360) begin
      n_errors++; $display("FAIL abort_words: %0d bad of %0d words expected 0 of 360", nbad, got_q.size());
    end
    n_checks++;
    if (err_size !== 1'b1 || n_done != 1 || frame_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL abort_status: size %b pulses %0d cnt %0d expected 1 1 1", err_size, n_done, frame_cnt);
    end
  endtask

  task automatic test_midframe_reset();
    int n_at_rst = 0;
    setup(8'd1, 16, 4);
    fork
      cam_frame(16, 4, -1, 10);
      begin
        repeat (14) tick();
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL pre_reset_busy: got %b expected 1", busy); end
        cam_rst = 1'b1;
        tick();
        n_at_rst = got_q.size();
        n_checks++;
        if ({out_data, out_valid, out_sof, out_eof, busy, frame_done, frame_cnt, err_overflow, err_size} !== 47'd0) begin
          n_errors++;
          $display("FAIL midframe_reset: data %h valid %b busy %b size %b expected all 0",
                   out_data, out_valid, busy, err_size);
        end
        cam_rst = 1'b0;
      end
    join
    repeat (4) tick();
    n_checks++;
    if (got_q.size() != n_at_rst || busy !== 1'b0) begin
      n_errors++; $display("FAIL post_reset_quiet: %0d new words busy %b expected 0 and 0",
                           got_q.size() - n_at_rst, busy);
    end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_single_frame();
    test_byte_order();
    test_size_error();
    test_overflow();
    test_continuous_stop();
    test_vsync_abort();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
